// File: rtl/zsy_disp_pkg.sv
// zsy_disp_pkg: scan state encoding, default timing constants and counter sizing
package zsy_disp_pkg;
  typedef enum logic [1:0] {ST_LAMP, ST_GUARD, ST_DRIVE} st_t;
  localparam int DEF_DIGITS = 4;
  localparam int DEF_DWELL = 1000;
  localparam int DEF_GUARD = 8;
  localparam int DEF_LT = 50000;
  localparam int DEF_LZB = 1;
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/zsy_disp_lzb_mask.sv
// zsy_disp_lzb_mask: flags leading-zero digits above digit 0 for blanking
module zsy_disp_lzb_mask #(
  parameter int DIGITS = 4,
  parameter int LZB = 1
) (
  input  logic [4*DIGITS-1:0] shadow,
  output logic [DIGITS-1:0]   mask
);
  logic z;
  always_comb begin
    mask = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      z = z && shadow[4*i +: 4] == 4'd0;
      mask[i] = LZB != 0 && z;
    end
  end
endmodule

// File: rtl/zsy_disp_scan_ctrl.sv
// zsy_disp_scan_ctrl: multiplexed 7-segment scan with tear-free frame commit, lamp test and blanking
module zsy_disp_scan_ctrl
  import zsy_disp_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int DWELL_CYCLES = DEF_DWELL,
  parameter int GUARD_CYCLES = DEF_GUARD,
  parameter int LT_CYCLES = DEF_LT,
  parameter int LZB = DEF_LZB
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                upd_valid,
  input  logic [4*DIGITS-1:0] upd_data,
  output logic                upd_ready,
  input  logic                lt_req,
  input  logic                blank,
  output logic [3:0]          dec_a,
  output logic                dec_le,
  output logic                dec_bi_n,
  output logic                dec_lt_n,
  output logic [DIGITS-1:0]   dig_sel,
  output logic                frame_tick
);
  localparam int CW = cnt_w(LT_CYCLES, DWELL_CYCLES, GUARD_CYCLES);
  localparam int IW = $clog2(DIGITS);
  st_t st, nst;
  logic [CW-1:0] cnt, ncnt, lim;
  logic [IW-1:0] idx, nidx;
  logic [4*DIGITS-1:0] shadow, nshadow, pending;
  logic [DIGITS-1:0] mask, n_dig_sel;
  logic [3:0] n_a;
  logic pend_full, npend_full, accept, commit, done, lamp, off;
  logic n_bi_n, n_le, n_lt_n, n_tick;
  zsy_disp_lzb_mask #(.DIGITS(DIGITS), .LZB(LZB)) u_lzb (.shadow(nshadow), .mask(mask));
  always_comb begin
    accept = upd_valid && upd_ready;
    commit = frame_tick && pend_full && !lt_req;
    npend_full = commit ? 1'b0 : accept ? 1'b1 : pend_full;
    nshadow = commit ? pending : shadow;
    lim = st == ST_LAMP ? CW'(LT_CYCLES - 1) : st == ST_GUARD ? CW'(GUARD_CYCLES - 1) : CW'(DWELL_CYCLES - 1);
    done = cnt == lim;
    nst = lt_req ? ST_LAMP : !done ? st : st == ST_GUARD ? ST_DRIVE : ST_GUARD;
    ncnt = lt_req ? CW'(LT_CYCLES - 1) : done ? '0 : cnt + 1'b1;
    nidx = (lt_req || st == ST_LAMP) ? '0 : !(done && st == ST_DRIVE) ? idx : idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
    lamp = nst == ST_LAMP;
    off = blank || nst == ST_GUARD;
    n_dig_sel = lamp ? '1 : off ? '0 : DIGITS'(1) << nidx;
    n_bi_n = lamp || !(off || mask[nidx]);
    n_le = nst == ST_GUARD;
    n_lt_n = !lamp;
    n_a = lamp ? 4'd0 : nshadow[4*nidx +: 4];
    n_tick = nst == ST_DRIVE && nidx == IW'(DIGITS - 1) && ncnt == CW'(DWELL_CYCLES - 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= ST_LAMP;
      cnt <= '0;
      idx <= '0;
      shadow <= '0;
      pending <= '0;
      pend_full <= 1'b0;
      upd_ready <= 1'b1;
      dig_sel <= '1;
      dec_a <= 4'd0;
      dec_le <= 1'b0;
      dec_bi_n <= 1'b1;
      dec_lt_n <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      st <= nst;
      cnt <= ncnt;
      idx <= nidx;
      shadow <= nshadow;
      pending <= accept ? upd_data : pending;
      pend_full <= npend_full;
      upd_ready <= !npend_full;
      dig_sel <= n_dig_sel;
      dec_a <= n_a;
      dec_le <= n_le;
      dec_bi_n <= n_bi_n;
      dec_lt_n <= n_lt_n;
      frame_tick <= n_tick;
    end
  end
endmodule

// File: tb/tb_zsy_disp_scan_ctrl.sv
// tb_zsy_disp_scan_ctrl: directed checks of lamp test, scan timing, commit, lzb, lt_req, blank and reset
module tb_zsy_disp_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic upd_valid = 1'b0;
  logic [15:0] upd_data = 16'h0000;
  logic lt_req = 1'b0;
  logic blank = 1'b0;
  logic upd_ready, dec_le, dec_bi_n, dec_lt_n, frame_tick;
  logic [3:0] dec_a, dig_sel;
  int cyc, n_checks, n_fail;
  logic [11:0] obs;
  zsy_disp_scan_ctrl #(.DIGITS(4), .DWELL_CYCLES(4), .GUARD_CYCLES(2), .LT_CYCLES(3), .LZB(1)) dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_data(upd_data), .upd_ready(upd_ready),
    .lt_req(lt_req), .blank(blank), .dec_a(dec_a), .dec_le(dec_le), .dec_bi_n(dec_bi_n),
    .dec_lt_n(dec_lt_n), .dig_sel(dig_sel), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  assign obs = {dig_sel, dec_bi_n, dec_le, dec_lt_n, dec_a, frame_tick};
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask
  task automatic goto(input int n);
    while (cyc < n) step();
  endtask
  task automatic test_reset();
    logic [11:0] e;
    upd_valid = 1'b1;
    upd_data = 16'h1234;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    e = {4'b1111, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
    n_checks++; if (obs !== e || upd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_state cyc %0d: got %h/%b want %h/1", cyc, obs, upd_ready, e); end
    step();
    upd_valid = 1'b0;
    n_checks++; if (upd_ready !== 1'b0) begin n_fail++; $display("FAIL accept_drop_ready cyc %0d: got %b want 0", cyc, upd_ready); end
    for (int c = 1; c < 12; c++) begin
      e = c < 3 ? {4'b1111, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0} : (c < 5 || c > 8 && c < 11) ? {4'b0000, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0} :
          c < 9 ? {4'b0001, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0} : {4'b0010, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0};
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL powerup_seq cyc %0d: got %h want %h", cyc, obs, e); end
      step();
    end
    goto(26);
    n_checks++; if (frame_tick !== 1'b1 || upd_ready !== 1'b0 || dig_sel !== 4'b1000) begin n_fail++; $display("FAIL first_tick cyc %0d: got tick %b rdy %b sel %b want 1 0 1000", cyc, frame_tick, upd_ready, dig_sel); end
    step();
  endtask
  task automatic test_frame();
    logic [15:0] v;
    logic [11:0] e;
    int d, p;
    v = 16'h1234;
    n_checks++; if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_commit cyc %0d: got %b want 1", cyc, upd_ready); end
    upd_valid = 1'b1;
    upd_data = 16'h0070;
    for (int k = 0; k < 24; k++) begin
      d = k / 6;
      p = k % 6;
      e = p < 2 ? {4'b0000, 1'b0, 1'b1, 1'b1, v[4*d +: 4], 1'b0} : {4'b0001 << d, 1'b1, 1'b0, 1'b1, v[4*d +: 4], k == 23};
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL frame_1234 cyc %0d: got %h want %h", cyc, obs, e); end
      step();
      upd_valid = 1'b0;
    end
  endtask
  task automatic test_lzb();
    logic [15:0] vals [2];
    logic [3:0] msks [2];
    logic [11:0] e;
    int d, p;
    vals = '{16'h0070, 16'h0000};
    msks = '{4'b1100, 4'b1110};
    upd_valid = 1'b1;
    upd_data = 16'h0000;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 24; k++) begin
        d = k / 6;
        p = k % 6;
        e = p < 2 ? {4'b0000, 1'b0, 1'b1, 1'b1, vals[f][4*d +: 4], 1'b0} : {4'b0001 << d, ~msks[f][d], 1'b0, 1'b1, vals[f][4*d +: 4], k == 23};
        n_checks++; if (obs !== e) begin n_fail++; $display("FAIL lzb_frame%0d cyc %0d: got %h want %h", f, cyc, obs, e); end
        step();
        upd_valid = 1'b0;
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [15:0] vals [3];
    logic [4:0] e;
    int d, f;
    vals = '{16'h0000, 16'hABCD, 16'h5678};
    n_checks++; if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_a cyc %0d: got %b want 1", cyc, upd_ready); end
    upd_valid = 1'b1;
    upd_data = 16'hABCD;
    step();
    upd_data = 16'h5678;
    while (cyc < 171) begin
      f = (cyc - 99) / 24;
      d = ((cyc - 99) % 24) / 6;
      e = {cyc == 123 || cyc >= 147, vals[f][4*d +: 4]};
      n_checks++; if ({upd_ready, dec_a} !== e) begin n_fail++; $display("FAIL b2b cyc %0d: got rdy/a %b/%h want %b/%h", cyc, upd_ready, dec_a, e[4], e[3:0]); end
      step();
      if (cyc == 124) upd_valid = 1'b0;
    end
  endtask
  task automatic test_lt_req();
    logic [11:0] e;
    goto(185);
    e = {4'b0100, 1'b1, 1'b0, 1'b1, 4'h6, 1'b0};
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL lt_pre cyc %0d: got %h want %h", cyc, obs, e); end
    lt_req = 1'b1;
    e = {4'b1111, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL lt_active cyc %0d: got %h want %h", cyc, obs, e); end
    end
    lt_req = 1'b0;
    step();
    e = {4'b0000, 1'b0, 1'b1, 1'b1, 4'h8, 1'b0};
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL lt_release_guard cyc %0d: got %h want %h", cyc, obs, e); end
    goto(190);
    e = {4'b0001, 1'b1, 1'b0, 1'b1, 4'h8, 1'b0};
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL lt_release_drive cyc %0d: got %h want %h", cyc, obs, e); end
  endtask
  task automatic test_blank();
    logic [11:0] e;
    blank = 1'b1;
    step();
    e = {4'b0000, 1'b0, 1'b0, 1'b1, 4'h8, 1'b0};
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL blank_d0 cyc %0d: got %h want %h", cyc, obs, e); end
    goto(205);
    e = {4'b0000, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0};
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL blank_d2 cyc %0d: got %h want %h", cyc, obs, e); end
    goto(211);
    e = {4'b0000, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1};
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL blank_tick cyc %0d: got %h want %h", cyc, obs, e); end
    blank = 1'b0;
    goto(214);
    e = {4'b0001, 1'b1, 1'b0, 1'b1, 4'h8, 1'b0};
    n_checks++; if (obs !== e) begin n_fail++; $display("FAIL unblank cyc %0d: got %h want %h", cyc, obs, e); end
  endtask
  task automatic test_async_rst();
    logic [11:0] e;
    int d, p;
    upd_valid = 1'b1;
    upd_data = 16'h9999;
    step();
    upd_valid = 1'b0;
    n_checks++; if (upd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pending_taken cyc %0d: got %b want 0", cyc, upd_ready); end
    #2 rst = 1'b1;
    #1;
    e = {4'b1111, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
    n_checks++; if (obs !== e || upd_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst: got %h/%b want %h/1", obs, upd_ready, e); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    goto(3);
    for (int k = 0; k < 48; k++) begin
      d = (k % 24) / 6;
      p = k % 6;
      e = p < 2 ? {4'b0000, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0} : {4'b0001 << d, d == 0, 1'b0, 1'b1, 4'h0, k % 24 == 23};
      n_checks++; if (obs !== e) begin n_fail++; $display("FAIL post_rst_frame cyc %0d: got %h want %h", cyc, obs, e); end
      step();
    end
  endtask
  initial begin
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_frame();
    test_lzb();
    test_back_to_back();
    test_lt_req();
    test_blank();
    test_async_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
